// File: rtl/op_result_log.sv
// op_result_log: circular history of captured ALU results, with a backward
// viewer for display and a saturating count of captures that had v=1.
module op_result_log #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture,
  input  logic [2:0]                 aluop,
  input  logic [5:0]                 a,
  input  logic [5:0]                 b,
  input  logic [5:0]                 result,
  input  logic                       z,
  input  logic                       v,
  input  logic                       n,
  input  logic                       step,
  input  logic                       clear,
  output logic [2:0]                 view_op,
  output logic [5:0]                 view_a,
  output logic [5:0]                 view_b,
  output logic [5:0]                 view_result,
  output logic [2:0]                 view_flags,
  output logic                       view_valid,
  output logic [$clog2(DEPTH)-1:0]   view_index,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 v_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [7:0] VMAX = 8'hFF;

  // One history entry, 24 bits.
  typedef struct packed {
    logic [2:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] res;
    logic       z;
    logic       v;
    logic       n;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;

  // Assemble the entry being captured this cycle.
  always_comb begin
    wr_entry     = '0;
    wr_entry.op  = aluop;
    wr_entry.a   = a;
    wr_entry.b   = b;
    wr_entry.res = result;
    wr_entry.z   = z;
    wr_entry.v   = v;
    wr_entry.n   = n;
  end

  // History storage; contents are don't-care until counted as valid.
  always_ff @(posedge clk) begin
    if (capture && !clear) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointer, occupancy, viewer and statistics; clear > capture > step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      count      <= '0;
      view_index <= '0;
      overflow   <= 1'b0;
      v_count    <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      count      <= '0;
      view_index <= '0;
      overflow   <= 1'b0;
      v_count    <= '0;
    end else if (capture) begin
      wr_ptr     <= AW'(wr_ptr + AW'(1));
      view_index <= '0;
      if (count == FULL) begin
        overflow <= 1'b1;
      end else begin
        count <= CW'(count + CW'(1));
      end
      if (v && (v_count != VMAX)) begin
        v_count <= 8'(v_count + 8'd1);
      end
    end else if (step && (count != '0)) begin
      if ({1'b0, view_index} == CW'(count - CW'(1))) begin
        view_index <= '0;
      end else begin
        view_index <= AW'(view_index + AW'(1));
      end
    end
  end

  // Newest entry sits just behind the write pointer; older ones further back.
  always_comb begin
    rd_addr  = AW'(wr_ptr - AW'(1) - view_index);
    rd_entry = mem[rd_addr];
  end

  // Viewer outputs, blanked while the log is empty.
  always_comb begin
    view_valid  = (count != '0);
    view_op     = '0;
    view_a      = '0;
    view_b      = '0;
    view_result = '0;
    view_flags  = '0;
    if (view_valid) begin
      view_op     = rd_entry.op;
      view_a      = rd_entry.a;
      view_b      = rd_entry.b;
      view_result = rd_entry.res;
      view_flags  = {rd_entry.z, rd_entry.v, rd_entry.n};
    end
  end

endmodule

// File: tb/tb_op_result_log.sv
// Directed bench for op_result_log (DEPTH=8).
module tb_op_result_log;

  logic       clk;
  logic       reset;
  logic       capture;
  logic [2:0] aluop;
  logic [5:0] a;
  logic [5:0] b;
  logic [5:0] result;
  logic       z;
  logic       v;
  logic       n;
  logic       step;
  logic       clear;
  logic [2:0] view_op;
  logic [5:0] view_a;
  logic [5:0] view_b;
  logic [5:0] view_result;
  logic [2:0] view_flags;
  logic       view_valid;
  logic [2:0] view_index;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] v_count;

  int nchk;
  int nerr;

  op_result_log #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .capture(capture), .aluop(aluop),
    .a(a), .b(b), .result(result), .z(z), .v(v), .n(n),
    .step(step), .clear(clear),
    .view_op(view_op), .view_a(view_a), .view_b(view_b),
    .view_result(view_result), .view_flags(view_flags),
    .view_valid(view_valid), .view_index(view_index),
    .count(count), .overflow(overflow), .v_count(v_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic drive(input logic cap, input logic stp, input logic clr,
                       input logic [2:0] op, input logic [5:0] ia,
                       input logic [5:0] ib, input logic [5:0] res,
                       input logic [2:0] fl);
    capture = cap; step = stp; clear = clr;
    aluop = op; a = ia; b = ib; result = res; {z, v, n} = fl;
    @(posedge clk);
    #1;
    capture = 1'b0; step = 1'b0; clear = 1'b0;
  endtask

  task automatic cap(input logic [2:0] op, input logic [5:0] ia,
                     input logic [5:0] ib, input logic [5:0] res,
                     input logic [2:0] fl);
    drive(1'b1, 1'b0, 1'b0, op, ia, ib, res, fl);
  endtask

  task automatic do_step();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 3'd0);
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b1, 3'd0, 6'd0, 6'd0, 6'd0, 3'd0);
  endtask

  initial begin
    nchk = 0; nerr = 0;
    reset = 1'b1; capture = 1'b0; step = 1'b0; clear = 1'b0;
    aluop = '0; a = '0; b = '0; result = '0; z = 1'b0; v = 1'b0; n = 1'b0;

    // Reset state, before any clock edge
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", view_valid, 0);
    chk("rst_index", view_index, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_vcount", v_count, 0);
    chk("rst_result", view_result, 0);
    #10 reset = 1'b0;

    // Step on empty log is ignored
    do_step();
    chk("empty_step_index", view_index, 0);
    chk("empty_step_count", count, 0);

    // First capture
    cap(3'd0, 6'd5, 6'd3, 6'd8, 3'b000);
    chk("cap1_count", count, 1);
    chk("cap1_result", view_result, 8);
    chk("cap1_a", view_a, 5);
    chk("cap1_b", view_b, 3);
    chk("cap1_valid", view_valid, 1);
    chk("cap1_index", view_index, 0);

    // Three back-to-back captures, then step backwards with wrap
    do_clear();
    chk("clr_count", count, 0);
    chk("clr_valid", view_valid, 0);
    cap(3'd1, 6'd10, 6'd20, 6'd1, 3'b100);
    cap(3'd2, 6'd11, 6'd21, 6'd2, 3'b010);
    cap(3'd6, 6'd12, 6'd22, 6'd3, 3'b101);
    chk("b2b_count", count, 3);
    chk("b2b_result", view_result, 3);
    chk("b2b_op", view_op, 6);
    chk("b2b_flags", view_flags, 5);
    chk("b2b_a", view_a, 12);
    do_step();
    chk("st1_result", view_result, 2);
    chk("st1_index", view_index, 1);
    chk("st1_op", view_op, 2);
    chk("st1_flags", view_flags, 2);
    do_step();
    chk("st2_result", view_result, 1);
    chk("st2_index", view_index, 2);
    do_step();
    chk("st3_result", view_result, 3);
    chk("st3_index", view_index, 0);

    // Fill past DEPTH
    do_clear();
    for (int i = 0; i < 8; i++) cap(3'd0, 6'd0, 6'd0, 6'(i), 3'b000);
    chk("full_count", count, 8);
    chk("full_overflow", overflow, 0);
    cap(3'd0, 6'd0, 6'd0, 6'd8, 3'b000);
    chk("ovf_count", count, 8);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_result", view_result, 8);
    for (int i = 0; i < 7; i++) do_step();
    chk("ovf_oldest_result", view_result, 1);
    chk("ovf_oldest_index", view_index, 7);
    do_step();
    chk("ovf_wrap_result", view_result, 8);
    chk("ovf_wrap_index", view_index, 0);
    chk("ovf_vcount", v_count, 0);

    // v_count saturation
    do_clear();
    for (int i = 0; i < 255; i++) cap(3'd1, 6'd0, 6'd0, 6'(i), 3'b010);
    chk("vsat_255", v_count, 255);
    for (int i = 255; i < 300; i++) cap(3'd1, 6'd0, 6'd0, 6'(i), 3'b010);
    chk("vsat_300", v_count, 255);
    chk("vsat_count", count, 8);
    chk("vsat_overflow", overflow, 1);
    chk("vsat_result", view_result, 43);
    do_clear();
    chk("clr2_vcount", v_count, 0);
    chk("clr2_count", count, 0);
    chk("clr2_overflow", overflow, 0);
    chk("clr2_valid", view_valid, 0);
    chk("clr2_result", view_result, 0);

    // Capture and step together: capture wins, index returns to 0
    cap(3'd0, 6'd0, 6'd0, 6'd5, 3'b000);
    cap(3'd0, 6'd0, 6'd0, 6'd6, 3'b000);
    do_step();
    chk("pre_cs_result", view_result, 5);
    chk("pre_cs_index", view_index, 1);
    drive(1'b1, 1'b1, 1'b0, 3'd0, 6'd0, 6'd0, 6'd9, 3'b000);
    chk("cs_index", view_index, 0);
    chk("cs_result", view_result, 9);
    chk("cs_count", count, 3);

    // Capture and clear together: clear wins
    drive(1'b1, 1'b0, 1'b1, 3'd0, 6'd0, 6'd0, 6'd7, 3'b010);
    chk("cc_count", count, 0);
    chk("cc_valid", view_valid, 0);
    chk("cc_vcount", v_count, 0);

    // Async reset mid-burst
    cap(3'd0, 6'd0, 6'd0, 6'd1, 3'b010);
    cap(3'd0, 6'd0, 6'd0, 6'd2, 3'b010);
    capture = 1'b1; result = 6'd3;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_count", count, 0);
    chk("areset_valid", view_valid, 0);
    chk("areset_vcount", v_count, 0);
    chk("areset_result", view_result, 0);
    capture = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_count", count, 0);
    cap(3'd4, 6'd1, 6'd2, 6'd7, 3'b000);
    chk("post_reset_cap_count", count, 1);
    chk("post_reset_cap_result", view_result, 7);
    chk("post_reset_cap_op", view_op, 4);
    do_step();
    chk("single_step_index", view_index, 0);
    chk("single_step_result", view_result, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
